// File: rtl/mlsu_meta_bcast_fifo.sv
// mlsu_meta_bcast_fifo: broadcasts MLSU meta beats to NUM_OUT consumers,
// each consumer draining its own DEPTH-entry FIFO independently.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_valid_i/ready_o  input beat handshake
//   in_dest_i           per-beat consumer mask (bit k -> consumer k)
//   in_data_i           payload
//   out_valid_o/ready_i per-consumer handshake
//   out_data_o          per-consumer head payload, packed k*DATA_W
//   occ_o               per-consumer occupancy, packed k*CNT_W
//   idle_o              all FIFOs empty
module mlsu_meta_bcast_fifo #(
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NUM_OUT-1:0]        in_dest_i,
  input  logic [DATA_W-1:0]         in_data_i,
  output logic [NUM_OUT-1:0]        out_valid_o,
  input  logic [NUM_OUT-1:0]        out_ready_i,
  output logic [NUM_OUT*DATA_W-1:0] out_data_o,
  output logic [NUM_OUT*CNT_W-1:0]  occ_o,
  output logic                      idle_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]  cnt_q [NUM_OUT];
  logic [CNT_W-1:0]  cnt_d [NUM_OUT];
  logic [PTR_W-1:0]  wr_q  [NUM_OUT];
  logic [PTR_W-1:0]  wr_d  [NUM_OUT];
  logic [PTR_W-1:0]  rd_q  [NUM_OUT];
  logic [PTR_W-1:0]  rd_d  [NUM_OUT];
  logic [DATA_W-1:0] mem_q [NUM_OUT][DEPTH];

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic               accept;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered occupancy, so a full FIFO
  // popping this cycle still blocks the push until next cycle.
  always_comb begin
    full = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      full[k] = (cnt_q[k] == CNT_W'(DEPTH));
    end
  end

  assign in_ready_o = &(~in_dest_i | ~full);
  assign accept     = in_valid_i & in_ready_o;
  assign push       = {NUM_OUT{accept}} & in_dest_i;
  assign pop        = out_valid_o & out_ready_i;

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      cnt_d[k] = cnt_q[k];
      wr_d[k]  = wr_q[k];
      rd_d[k]  = rd_q[k];
      if (push[k]) wr_d[k] = inc(wr_q[k]);
      if (pop[k])  rd_d[k] = inc(rd_q[k]);
      unique case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
        2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        cnt_q[k] <= '0;
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        cnt_q[k] <= cnt_d[k];
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
      end
    end
  end

  // Payload storage carries no reset; validity comes from cnt_q.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (push[k] && !rst_i) mem_q[k][wr_q[k]] <= in_data_i;
    end
  end

  always_comb begin
    out_valid_o = '0;
    out_data_o  = '0;
    occ_o       = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_valid_o[k]                   = (cnt_q[k] != '0);
      out_data_o[k*DATA_W +: DATA_W]   = mem_q[k][rd_q[k]];
      occ_o[k*CNT_W +: CNT_W]          = cnt_q[k];
    end
  end

  assign idle_o = ~|out_valid_o;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_chk
    a_no_ovf: assert property (
      @(posedge clk_i) disable iff (rst_i)
      push[k] |-> !full[k]);
    a_no_udf: assert property (
      @(posedge clk_i) disable iff (rst_i)
      pop[k] |-> (cnt_q[k] != '0));
  end

  a_in_hold: assert property (
    @(posedge clk_i) disable iff (rst_i)
    in_valid_i && !in_ready_o |=>
      in_valid_i && $stable(in_data_i) && $stable(in_dest_i));

endmodule

// File: tb/tb_mlsu_meta_bcast_fifo.sv
// tb_mlsu_meta_bcast_fifo: scoreboard bench for the meta broadcast FIFO,
// DUT a at DEPTH=2 and DUT b at DEPTH=3 sharing clock and reset.
module tb_mlsu_meta_bcast_fifo;

  logic        clk;
  logic        rst;

  logic        a_valid, a_ready, a_idle;
  logic [1:0]  a_dest, a_ovalid, a_oready;
  logic [63:0] a_data;
  logic [127:0] a_odata;
  logic [3:0]  a_occ;

  logic        b_valid, b_ready, b_idle;
  logic [1:0]  b_dest, b_ovalid, b_oready;
  logic [63:0] b_data;
  logic [127:0] b_odata;
  logic [3:0]  b_occ;

  logic [63:0] qa [2][$];
  logic [63:0] qb [2][$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  mlsu_meta_bcast_fifo #(.NUM_OUT(2), .DEPTH(2)) u_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_valid), .in_ready_o(a_ready),
    .in_dest_i(a_dest), .in_data_i(a_data),
    .out_valid_o(a_ovalid), .out_ready_i(a_oready),
    .out_data_o(a_odata), .occ_o(a_occ), .idle_o(a_idle)
  );

  mlsu_meta_bcast_fifo #(.NUM_OUT(2), .DEPTH(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_valid), .in_ready_o(b_ready),
    .in_dest_i(b_dest), .in_data_i(b_data),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready),
    .out_data_o(b_odata), .occ_o(b_occ), .idle_o(b_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: valid must track the model queue; head must match.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("a_valid%0d", k), 64'(a_ovalid[k]),
            64'(qa[k].size() != 0));
        if (a_ovalid[k] && qa[k].size() != 0) begin
          chk($sformatf("a_data%0d", k), a_odata[k*64 +: 64], qa[k][0]);
          if (a_oready[k]) void'(qa[k].pop_front());
        end
        chk($sformatf("b_valid%0d", k), 64'(b_ovalid[k]),
            64'(qb[k].size() != 0));
        if (b_ovalid[k] && qb[k].size() != 0) begin
          chk($sformatf("b_data%0d", k), b_odata[k*64 +: 64], qb[k][0]);
          if (b_oready[k]) void'(qb[k].pop_front());
        end
      end
    end
  end

  // One clock: record acceptance, push expected beats to the scoreboard.
  task automatic cyc(output logic aa, output logic ab);
    @(negedge clk);
    aa = a_valid & a_ready & !rst;
    ab = b_valid & b_ready & !rst;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        qa[k].delete();
        qb[k].delete();
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (aa && a_dest[k]) qa[k].push_back(a_data);
        if (ab && b_dest[k]) qb[k].push_back(b_data);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    logic aa, ab;
    a_valid = 0; b_valid = 0;
    a_oready = '0; b_oready = '0;
    rst = 1;
    cyc(aa, ab);
    rst = 0;
  endtask

  task automatic drain(input string nm);
    logic aa, ab;
    int n;
    n = 0;
    a_valid = 0; b_valid = 0;
    a_oready = '1; b_oready = '1;
    while (!(a_idle && b_idle) && n < 20) begin
      cyc(aa, ab);
      n++;
    end
    chk({nm, "_idle"}, 64'(a_idle & b_idle), 64'd1);
    chk({nm, "_qempty"},
        64'(qa[0].size() + qa[1].size() + qb[0].size() + qb[1].size()),
        64'd0);
    a_oready = '0; b_oready = '0;
  endtask

  initial begin
    logic aa, ab;
    rst = 1;
    a_valid = 0; a_dest = '0; a_data = '0; a_oready = '0;
    b_valid = 0; b_dest = '0; b_data = '0; b_oready = '0;
    cyc(aa, ab);
    cyc(aa, ab);
    rst = 0;
    mon_en = 1'b1;

    chk("rst_ovalid", 64'(a_ovalid), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_idle", 64'(a_idle), 64'd1);
    a_dest = 2'b11;
    #1;
    chk("rst_ready", 64'(a_ready), 64'd1);
    chk("rst_b_occ", 64'(b_occ), 64'd0);

    // 1: fill both FIFOs, no consumer ready
    a_valid = 1; a_dest = 2'b11; a_data = 64'hA;
    cyc(aa, ab); chk("t1_accA", 64'(aa), 64'd1);
    a_data = 64'hB;
    cyc(aa, ab); chk("t1_accB", 64'(aa), 64'd1);
    a_valid = 0;
    chk("t1_occ22", 64'(a_occ), 64'hA);
    chk("t1_idle0", 64'(a_idle), 64'd0);
    a_dest = 2'b11; cyc(aa, ab);
    chk("t1_rdy11", 64'(a_ready), 64'd0);
    a_dest = 2'b01; cyc(aa, ab);
    chk("t1_rdy01", 64'(a_ready), 64'd0);
    a_dest = 2'b10; cyc(aa, ab);
    chk("t1_rdy10", 64'(a_ready), 64'd0);
    a_dest = 2'b00; cyc(aa, ab);
    chk("t1_rdy00", 64'(a_ready), 64'd1);
    drain("t1");

    // 2: skewed drain, consumer 1 stalled
    do_reset();
    a_oready = 2'b01;
    a_valid = 1; a_dest = 2'b11; a_data = 64'h2A;
    cyc(aa, ab); chk("t2_accA", 64'(aa), 64'd1);
    a_data = 64'h2B;
    cyc(aa, ab); chk("t2_accB", 64'(aa), 64'd1);
    a_data = 64'h2C;
    cyc(aa, ab); chk("t2_stallC0", 64'(aa), 64'd0);
    cyc(aa, ab); chk("t2_stallC1", 64'(aa), 64'd0);
    chk("t2_occ20", 64'(a_occ), 64'h8);
    a_oready = 2'b10;
    cyc(aa, ab); chk("t2_popcyc", 64'(aa), 64'd0);
    a_oready = 2'b00;
    cyc(aa, ab); chk("t2_accC", 64'(aa), 64'd1);
    a_valid = 0;
    chk("t2_occ21", 64'(a_occ), 64'h9);
    drain("t2");

    // 3: routing by mask, dest 0 dropped
    do_reset();
    a_valid = 1;
    a_dest = 2'b01; a_data = 64'h3001;
    cyc(aa, ab); chk("t3_accX", 64'(aa), 64'd1);
    a_dest = 2'b10; a_data = 64'h3002;
    cyc(aa, ab); chk("t3_accY", 64'(aa), 64'd1);
    a_dest = 2'b00; a_data = 64'h3003;
    cyc(aa, ab); chk("t3_accZ", 64'(aa), 64'd1);
    a_valid = 0;
    chk("t3_occ11", 64'(a_occ), 64'h5);
    drain("t3");

    // 4: DEPTH=3 streaming with wrap
    do_reset();
    b_oready = 2'b11;
    b_valid = 1; b_dest = 2'b11;
    for (int i = 1; i <= 7; i++) begin
      b_data = 64'(i);
      cyc(aa, ab);
      chk($sformatf("t4_acc%0d", i), 64'(ab), 64'd1);
      chk($sformatf("t4_occ%0d", i), 64'(b_occ), 64'h5);
    end
    b_valid = 0;
    drain("t4");

    // 5: full FIFO popping does not accept the same cycle
    do_reset();
    a_valid = 1; a_dest = 2'b11; a_data = 64'h51;
    cyc(aa, ab);
    a_data = 64'h52;
    cyc(aa, ab);
    chk("t5_occ22", 64'(a_occ), 64'hA);
    a_oready = 2'b11; a_data = 64'h53;
    chk("t5_rdy0", 64'(a_ready), 64'd0);
    cyc(aa, ab); chk("t5_noacc", 64'(aa), 64'd0);
    chk("t5_occ11", 64'(a_occ), 64'h5);
    chk("t5_rdy1", 64'(a_ready), 64'd1);
    a_oready = 2'b00;
    cyc(aa, ab); chk("t5_acc", 64'(aa), 64'd1);
    a_valid = 0;
    chk("t5_occ22b", 64'(a_occ), 64'hA);
    drain("t5");

    // 6: reset mid-operation discards buffered beats
    do_reset();
    a_valid = 1; a_dest = 2'b11; a_data = 64'h61;
    cyc(aa, ab);
    a_dest = 2'b01; a_data = 64'h62;
    cyc(aa, ab);
    a_valid = 0;
    chk("t6_occ21", 64'(a_occ), 64'h6);
    do_reset();
    chk("t6_ovalid", 64'(a_ovalid), 64'd0);
    chk("t6_occ", 64'(a_occ), 64'd0);
    chk("t6_idle", 64'(a_idle), 64'd1);
    a_dest = 2'b11;
    #1;
    chk("t6_ready", 64'(a_ready), 64'd1);
    a_valid = 1; a_data = 64'h63;
    cyc(aa, ab); chk("t6_accR", 64'(aa), 64'd1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
